int2fp_conv: RTL

Parametrised multi-cycle converter from a signed or unsigned integer to an IEEE 754 binary floating-point word. It supports any exponent and mantissa width, selectable rounding, and overflow/inexact flags. It is the general successor to the fixed 16-bit-to-half converter and sits in the same numeric-conversion path. It uses the same R_I/R_O handshake on a single clock.

---
 rtl/int2fp_conv.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/int2fp_conv.sv
// int2fp_conv: multi-cycle integer to IEEE 754 binary floating-point converter.
// Converts a signed or unsigned INT_W-bit integer into a {sign, exponent, mantissa}
// word with EXP_W exponent bits and MAN_W stored-mantissa bits, using either
// truncation or round-to-nearest-even. Overflow saturates to +/-infinity.
//
// Ports:
//   clk      - clock, all logic on rising edge
//   reset    - synchronous, active-high
//   dataIn   - integer operand, latched on accept
//   rnd      - rounding mode (0 = truncate, 1 = nearest-even), latched on accept
//   R_I      - request, accepted only while idle
//   dataOut  - converted result, held until the next result
//   R_O      - one-cycle pulse marking dataOut/ovf/inexact valid
//   busy     - high from accept until the result edge
//   ovf      - result saturated to infinity
//   inexact  - discarded bits were nonzero
//
// state | meaning
// IDLE  | waiting for R_I
// ABS   | take magnitude, short-cut zero
// NORM  | shift left until the leading 1 reaches the MSB
// ROUND | round, bias exponent, write result
module int2fp_conv #(
    parameter int INT_W  = 16,
    parameter int EXP_W  = 5,
    parameter int MAN_W  = 10,
    parameter int SIGNED = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [INT_W-1:0]         dataIn,
    input  logic                     rnd,
    input  logic                     R_I,
    output logic [EXP_W+MAN_W:0]     dataOut,
    output logic                     R_O,
    output logic                     busy,
    output logic                     ovf,
    output logic                     inexact
);

    // e only ever spans 0..INT_W-1
    localparam int E_W   = $clog2(INT_W);
    // Biased exponent width: room for BIAS + (INT_W-1) + rounding carry without wrap
    localparam int EB_W  = ((EXP_W > E_W) ? EXP_W : E_W) + 2;
    // Bits below the leading 1, padded so m, G and S always exist
    localparam int EXT_W = INT_W + MAN_W + 1;

    localparam logic [EB_W-1:0] BIAS = {{(EB_W-EXP_W+1){1'b0}}, {(EXP_W-1){1'b1}}};
    localparam logic [EB_W-1:0] EMAX = {{(EB_W-EXP_W){1'b0}}, {EXP_W{1'b1}}};

    typedef enum logic [1:0] {IDLE, ABS, NORM, ROUND} state_t;

    state_t           state;
    logic [INT_W-1:0] mag;
    logic [E_W-1:0]   e;
    logic             sign_r;
    logic             rnd_r;

    logic [EXT_W-1:0] ext;
    logic [MAN_W-1:0] m_trunc;
    logic             g_bit;
    logic             s_bit;
    logic             round_up;
    logic [MAN_W:0]   m_sum;
    logic [EB_W-1:0]  eb;

    always_comb begin
        ext      = {mag[INT_W-2:0], {(MAN_W+2){1'b0}}};
        m_trunc  = ext[EXT_W-1 -: MAN_W];
        g_bit    = ext[EXT_W-1-MAN_W];
        s_bit    = |ext[EXT_W-2-MAN_W:0];
        round_up = rnd_r & g_bit & (s_bit | m_trunc[0]);
        // A carry out of the mantissa leaves m_sum[MAN_W-1:0] at zero and bumps e
        m_sum    = {1'b0, m_trunc} + (MAN_W+1)'(round_up);
        eb       = EB_W'(e) + BIAS + EB_W'(m_sum[MAN_W]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            mag     <= '0;
            e       <= '0;
            sign_r  <= 1'b0;
            rnd_r   <= 1'b0;
            dataOut <= '0;
            R_O     <= 1'b0;
            busy    <= 1'b0;
            ovf     <= 1'b0;
            inexact <= 1'b0;
        end else begin
            R_O <= 1'b0;
            case (state)
                IDLE: begin
                    if (R_I) begin
                        mag    <= dataIn;
                        rnd_r  <= rnd;
                        sign_r <= (SIGNED != 0) && dataIn[INT_W-1];
                        busy   <= 1'b1;
                        state  <= ABS;
                    end
                end
                ABS: begin
                    // Negating the most negative value gives 2^(INT_W-1) as unsigned
                    if (mag == '0) begin
                        dataOut <= '0;
                        ovf     <= 1'b0;
                        inexact <= 1'b0;
                        R_O     <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        mag   <= sign_r ? (~mag + 1'b1) : mag;
                        e     <= E_W'(INT_W-1);
                        state <= NORM;
                    end
                end
                NORM: begin
                    if (mag[INT_W-1]) begin
                        state <= ROUND;
                    end else begin
                        mag <= mag << 1;
                        e   <= e - 1'b1;
                    end
                end
                ROUND: begin
                    inexact <= g_bit | s_bit;
                    if (eb >= EMAX) begin
                        dataOut <= {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        ovf     <= 1'b1;
                    end else begin
                        dataOut <= {sign_r, eb[EXP_W-1:0], m_sum[MAN_W-1:0]};
                        ovf     <= 1'b0;
                    end
                    R_O   <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
